// File: rtl/team_03_wb_master_arbiter_if.sv
// Requester and Wishbone master signal bundle for the round-robin master arbiter.
// master: arbiter side. slave: environment side (requesters plus Wishbone slave).
interface team_03_wb_master_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_we_i;
  logic [32*NUM_REQ-1:0] req_adr_i;
  logic [32*NUM_REQ-1:0] req_dat_i;
  logic [4*NUM_REQ-1:0]  req_sel_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [31:0]           rsp_dat_o;
  logic                  rsp_err_o;
  logic                  busy_o;
  logic [31:0]           ADR_O;
  logic [31:0]           DAT_O;
  logic [3:0]            SEL_O;
  logic                  WE_O;
  logic                  STB_O;
  logic                  CYC_O;
  logic [31:0]           DAT_I;
  logic                  ACK_I;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i,
    input  req_dat_i, req_sel_i, DAT_I, ACK_I,
    output req_ready_o, rsp_valid_o, rsp_dat_o,
    output rsp_err_o, busy_o, ADR_O, DAT_O,
    output SEL_O, WE_O, STB_O, CYC_O
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i,
    output req_dat_i, req_sel_i, DAT_I, ACK_I,
    input  req_ready_o, rsp_valid_o, rsp_dat_o,
    input  rsp_err_o, busy_o, ADR_O, DAT_O,
    input  SEL_O, WE_O, STB_O, CYC_O
  );
endinterface

// File: rtl/team_03_wb_master_arbiter.sv
// Round-robin arbiter sharing one single-beat Wishbone master among NUM_REQ requesters.
// Ports: clk_i, rst_i (sync, active-high), bus (team_03_wb_master_arbiter_if.master).
// Optional ACK timeout abort is enabled by defining WB_ARB_TIMEOUT_EN.
module team_03_wb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst_i,
  team_03_wb_master_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  logic [0:0]         state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      gnt;
  logic [NUM_REQ-1:0] ready_q;
  logic [NUM_REQ-1:0] rsp_q;
  logic [31:0]        rdat_q;
  logic [31:0]        adr_q;
  logic [31:0]        dat_q;
  logic [3:0]         sel_q;
  logic               we_q;
  logic               cyc_q;
  logic               busy_q;

  logic          found;
  logic [IW-1:0] pick;

  // First valid requester after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && bus.req_valid_i[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          expire;

  // Last waiting cycle: this edge would bring the count to TIMEOUT_CYCLES.
  assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_err_o = err_q;
`else
  assign bus.rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      gnt        <= '0;
      ready_q    <= '0;
      rsp_q      <= '0;
      rdat_q     <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
      rsp_q   <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt           <= pick;
            adr_q         <= bus.req_adr_i[32*pick +: 32];
            dat_q         <= bus.req_dat_i[32*pick +: 32];
            sel_q         <= bus.req_sel_i[4*pick +: 4];
            we_q          <= bus.req_we_i[pick];
            cyc_q         <= 1'b1;
            busy_q        <= 1'b1;
            ready_q[pick] <= 1'b1;
            state         <= BUS;
`ifdef WB_ARB_TIMEOUT_EN
            cnt           <= '0;
`endif
          end
        end
        BUS: begin
          if (bus.ACK_I) begin
            if (!we_q) rdat_q <= bus.DAT_I;
            cyc_q      <= 1'b0;
            busy_q     <= 1'b0;
            rsp_q[gnt] <= 1'b1;
            last_grant <= gnt;
            state      <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (expire) begin
            rdat_q     <= 32'hDEAD_BEEF;
            err_q      <= 1'b1;
            cyc_q      <= 1'b0;
            busy_q     <= 1'b0;
            rsp_q[gnt] <= 1'b1;
            last_grant <= gnt;
            state      <= IDLE;
          end else begin
            cnt        <= cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_q;
  assign bus.rsp_dat_o   = rdat_q;
  assign bus.busy_o      = busy_q;
  assign bus.ADR_O       = adr_q;
  assign bus.DAT_O       = dat_q;
  assign bus.SEL_O       = sel_q;
  assign bus.WE_O        = we_q;
  assign bus.STB_O       = cyc_q;
  assign bus.CYC_O       = cyc_q;
endmodule

// File: tb/tb_team_03_wb_master_arbiter.sv
// Testbench for team_03_wb_master_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_team_03_wb_master_arbiter;
  localparam int N  = 2;
  localparam int TO = 4;

  localparam logic [31:0] A0 = 32'h3000_0010;
  localparam logic [31:0] A1 = 32'h4000_0020;
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_1111;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  team_03_wb_master_arbiter_if #(.NUM_REQ(N)) bus ();

  team_03_wb_master_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pk(
    logic [1:0] rdy, logic [1:0] rsp, logic cyc, logic stb,
    logic we, logic err, logic busy, logic [31:0] adr,
    logic [31:0] dat, logic [3:0] sel, logic [31:0] rdat);
    return {19'd0, rdy, rsp, cyc, stb, we, err, busy,
            adr, dat, sel, rdat};
  endfunction

  function automatic logic [127:0] dut_out();
    return pk(bus.req_ready_o, bus.rsp_valid_o, bus.CYC_O,
              bus.STB_O, bus.WE_O, bus.rsp_err_o, bus.busy_o,
              bus.ADR_O, bus.DAT_O, bus.SEL_O, bus.rsp_dat_o);
  endfunction

  task automatic fixed_payload();
    bus.req_adr_i = {A1, A0};
    bus.req_dat_i = {D1, D0};
    bus.req_sel_i = {S1, S0};
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.req_valid_i = '0;
    bus.req_we_i    = '0;
    bus.ACK_I       = 1'b0;
    bus.DAT_I       = '0;
    fixed_payload();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  we;
    logic        ack;
    logic [31:0] dati;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rsp;
    logic        e_cyc;
    logic        e_we;
    logic [31:0] e_adr;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t vt[13];

  // Reference model state (transaction level).
  int          m_owner;
  int          m_last;
  int          m_wait;
  logic [1:0]  e_rdy, e_rsp;
  logic        e_cyc, e_we, e_err;
  logic [31:0] e_adr, e_dat, e_rdat;
  logic [3:0]  e_sel;

  logic [31:0] radr[N];
  logic [31:0] rdw[N];
  logic [3:0]  rsel[N];
  logic        rwe[N];
  logic        rv[N];

  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_step(logic [N-1:0] v, logic ack,
                            logic [31:0] dati);
    int g;
    e_rdy = '0;
    e_rsp = '0;
    if (m_owner < 0) begin
      g = rr_pick(m_last, v);
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        e_cyc    = 1'b1;
        e_adr    = radr[g];
        e_dat    = rdw[g];
        e_sel    = rsel[g];
        e_we     = rwe[g];
        m_owner  = g;
        m_wait   = 0;
      end
    end else if (ack) begin
      e_rsp[m_owner] = 1'b1;
      e_cyc = 1'b0;
      e_err = 1'b0;
      if (!e_we) e_rdat = dati;
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_wait++;
`ifdef WB_ARB_TIMEOUT_EN
      if (m_wait == TO) begin
        e_rsp[m_owner] = 1'b1;
        e_cyc   = 1'b0;
        e_err   = 1'b1;
        e_rdat  = 32'hDEAD_BEEF;
        m_last  = m_owner;
        m_owner = -1;
      end
`endif
    end
  endtask

  initial begin
    vt[0]  = '{2'b01, 2'b00, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 1'b0, A0, 32'h0};
    vt[1]  = '{2'b00, 2'b00, 1'b1, 32'h1234_5678, 2'b00, 2'b01, 1'b0, 1'b0, A0, 32'h1234_5678};
    vt[2]  = '{2'b00, 2'b00, 1'b1, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 1'b0, A0, 32'h1234_5678};
    vt[3]  = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, A0, 32'h1234_5678};
    vt[4]  = '{2'b11, 2'b11, 1'b1, 32'h5555_5555, 2'b10, 2'b00, 1'b1, 1'b1, A1, 32'h1234_5678};
    vt[5]  = '{2'b11, 2'b11, 1'b1, 32'h5555_5555, 2'b00, 2'b10, 1'b0, 1'b1, A1, 32'h1234_5678};
    vt[6]  = '{2'b11, 2'b11, 1'b1, 32'h5555_5555, 2'b01, 2'b00, 1'b1, 1'b1, A0, 32'h1234_5678};
    vt[7]  = '{2'b11, 2'b11, 1'b1, 32'h5555_5555, 2'b00, 2'b01, 1'b0, 1'b1, A0, 32'h1234_5678};
    vt[8]  = '{2'b11, 2'b11, 1'b1, 32'h5555_5555, 2'b10, 2'b00, 1'b1, 1'b1, A1, 32'h1234_5678};
    vt[9]  = '{2'b11, 2'b11, 1'b1, 32'h5555_5555, 2'b00, 2'b10, 1'b0, 1'b1, A1, 32'h1234_5678};
    vt[10] = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b1, A1, 32'h1234_5678};
    vt[11] = '{2'b10, 2'b00, 1'b0, 32'h0,         2'b10, 2'b00, 1'b1, 1'b0, A1, 32'h1234_5678};
    vt[12] = '{2'b00, 2'b00, 1'b1, 32'hCAFE_F00D, 2'b00, 2'b10, 1'b0, 1'b0, A1, 32'hCAFE_F00D};

    do_reset();
    check("reset", dut_out(), 128'd0);

    // Vector table: read, spurious ACK, back-to-back writes, read from 1.
    for (int i = 0; i < 13; i++) begin
      bus.req_valid_i = vt[i].v;
      bus.req_we_i    = vt[i].we;
      bus.ACK_I       = vt[i].ack;
      bus.DAT_I       = vt[i].dati;
      tick();
      check($sformatf("vec%0d", i),
        {56'd0, bus.req_ready_o, bus.rsp_valid_o, bus.CYC_O,
         bus.STB_O, bus.WE_O, bus.busy_o, bus.ADR_O, bus.rsp_dat_o},
        {56'd0, vt[i].e_rdy, vt[i].e_rsp, vt[i].e_cyc,
         vt[i].e_cyc, vt[i].e_we, vt[i].e_cyc, vt[i].e_adr,
         vt[i].e_rdat});
    end

    // Slow slave: five wait cycles, payload inputs scrambled meanwhile.
    do_reset();
    bus.req_valid_i = 2'b01;
    bus.req_we_i    = 2'b01;
    tick();
    check("slow_grant", {126'd0, bus.req_ready_o}, 128'd1);
    bus.req_valid_i = 2'b00;
    bus.req_adr_i   = '1;
    bus.req_dat_i   = '0;
    bus.req_sel_i   = '0;
    bus.req_we_i    = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("slow_hold%0d", i),
        {54'd0, bus.CYC_O, bus.STB_O, bus.WE_O, bus.rsp_valid_o,
         bus.ADR_O, bus.DAT_O, bus.SEL_O},
        {54'd0, 1'b1, 1'b1, 1'b1, 2'b00, A0, D0, S0});
    end
    bus.ACK_I = 1'b1;
    tick();
    check("slow_rsp", {124'd0, bus.rsp_valid_o, bus.CYC_O, bus.STB_O},
          {124'd0, 2'b01, 1'b0, 1'b0});
    bus.ACK_I = 1'b0;
    tick();
    check("slow_once", {126'd0, bus.rsp_valid_o}, 128'd0);

    // Reset during the third BUS cycle.
    do_reset();
    bus.req_valid_i = 2'b10;
    tick();
    check("mid_grant", {126'd0, bus.req_ready_o}, 128'd2);
    bus.req_valid_i = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst",
      {122'd0, bus.CYC_O, bus.STB_O, bus.rsp_valid_o, bus.busy_o, bus.rsp_err_o},
      128'd0);
    bus.req_valid_i = 2'b11;
    tick();
    check("mid_regrant", {126'd0, bus.req_ready_o}, 128'd1);

`ifdef WB_ARB_TIMEOUT_EN
    do_reset();
    bus.req_valid_i = 2'b01;
    tick();
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("to_wait%0d", i),
            {125'd0, bus.CYC_O, bus.rsp_valid_o}, {125'd0, 3'b100});
    end
    tick();
    check("to_abort",
      {92'd0, bus.rsp_valid_o, bus.rsp_err_o, bus.CYC_O, bus.rsp_dat_o},
      {92'd0, 2'b01, 1'b1, 1'b0, 32'hDEAD_BEEF});
    bus.req_valid_i = 2'b10;
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    tick();
    tick();
    bus.ACK_I = 1'b1;
    bus.DAT_I = 32'h0BAD_CAFE;
    tick();
    bus.ACK_I = 1'b0;
    check("to_ack_wins",
      {92'd0, bus.rsp_valid_o, bus.rsp_err_o, bus.CYC_O, bus.rsp_dat_o},
      {92'd0, 2'b10, 1'b0, 1'b0, 32'h0BAD_CAFE});
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_wait  = 0;
    e_rdy = '0; e_rsp = '0; e_cyc = 1'b0; e_we = 1'b0;
    e_err = 1'b0; e_adr = '0; e_dat = '0; e_rdat = '0; e_sel = '0;
    for (int i = 0; i < N; i++) begin
      radr[i] = $urandom;
      rdw[i]  = $urandom;
      rsel[i] = 4'($urandom);
      rwe[i]  = 1'($urandom);
      rv[i]   = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) begin
        v[i] = rv[i];
        bus.req_adr_i[32*i +: 32] = radr[i];
        bus.req_dat_i[32*i +: 32] = rdw[i];
        bus.req_sel_i[4*i +: 4]   = rsel[i];
        bus.req_we_i[i]           = rwe[i];
      end
      bus.req_valid_i = v;
      bus.ACK_I = ($urandom_range(0, 9) < 4);
      bus.DAT_I = $urandom;
      model_step(v, bus.ACK_I, bus.DAT_I);
      tick();
      check($sformatf("rand%0d", c), dut_out(),
        pk(e_rdy, e_rsp, e_cyc, e_cyc, e_we, e_err, m_owner >= 0,
           e_adr, e_dat, e_sel, e_rdat));
      for (int i = 0; i < N; i++) begin
        if (e_rdy[i]) begin
          radr[i] = $urandom;
          rdw[i]  = $urandom;
          rsel[i] = 4'($urandom);
          rwe[i]  = 1'($urandom);
          rv[i]   = 1'($urandom);
        end else if (!rv[i]) begin
          rv[i] = ($urandom_range(0, 2) == 0);
        end else if ($urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
